// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin WISHBONE bus arbiter for up to 8 masters.
// Arbitration looks only at cyc_i. A grant is held until the granted master
// drops cyc_i, and there is one idle cycle between grants.
// Optional watchdog: define WB_RR_ARBITER_TIMEOUT_EN to abort strobes that
// stall for TIMEOUT_CYCLES cycles with no termination. When a stall times
// out, the granted master gets a single to_err_o pulse and to_count_o counts
// the event.
//
// state | meaning
// IDLE  | no grant held; arbitrate among cyc_i requests
// GRANT | grant held; watchdog armed on stalled strobes
// ABORT | timeout issued; grant held until master drops cyc_i
module wb_rr_arbiter #(
  parameter int  NUM_MASTERS    = 2,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] cyc_i,
  input  logic [NUM_MASTERS-1:0] stb_i,
  input  logic                   ack_i,
  input  logic                   err_i,
  input  logic                   rty_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]       gnt_idx_o,
  output logic                   busy_o,
  output logic                   to_err_o,
  output logic [15:0]            to_count_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam logic [1:0] ABORT = 2'd2;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] cand_idx;

  // First requester at or above ptr, wrapping from the top master back to 0
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand_idx = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
      if (!pick_found && cyc_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  logic [15:0] wd;
  logic        stall;

  // Granted master is strobing and the slave has not terminated the access
  always_comb begin
    stall = stb_i[gnt_idx_o] && !(ack_i || err_i || rty_i);
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{stb_i, ack_i, err_i, rty_i, (TIMEOUT_CYCLES > 0)};
  assign to_err_o      = 1'b0;
  assign to_count_o    = 16'h0000;
`endif

  // Grant FSM, rotating pointer and (optionally) stall watchdog
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      ptr       <= '0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      wd         <= '0;
      to_err_o   <= 1'b0;
      to_count_o <= '0;
`endif
    end else begin
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      to_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= GRANT;
            gnt_o     <= NUM_MASTERS'(1) << pick_idx;
            gnt_idx_o <= pick_idx;
          end
        end
        default: begin
          if (!cyc_i[gnt_idx_o]) begin
            state <= IDLE;
            gnt_o <= '0;
            ptr   <= (gnt_idx_o == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
`ifdef WB_RR_ARBITER_TIMEOUT_EN
            wd    <= '0;
`endif
          end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
          else if (state == GRANT) begin
            if (stall) begin
              if (wd == WD_LAST) begin
                wd       <= '0;
                to_err_o <= 1'b1;
                state    <= ABORT;
                if (to_count_o != 16'hFFFF) to_count_o <= to_count_o + 16'd1;
              end else begin
                wd <= wd + 16'd1;
              end
            end else begin
              wd <= '0;
            end
          end
`endif
        end
      endcase
    end
  end

  assign busy_o = |gnt_o;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter (NUM_MASTERS=4, TIMEOUT_CYCLES=8).
// The driver pushes the reference model's expected post-edge outputs; the
// monitor pops them one cycle later and compares against the DUT.
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int T  = 8;
  localparam int IW = 2;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  cyc_i, stb_i;
  logic          ack_i, err_i, rty_i;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          busy_o, to_err_o;
  logic [15:0]   to_count_o;

  always #5 clk_i = ~clk_i;

  wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .gnt_o(gnt_o),
    .gnt_idx_o(gnt_idx_o), .busy_o(busy_o), .to_err_o(to_err_o),
    .to_count_o(to_count_o)
  );

  typedef struct {
    int gnt;
    int idx;
    int busy;
    int err;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, where the search starts, how long
  // the current stall has lasted and whether a timeout was already issued.
  int owner    = -1;
  int last_idx = 0;
  int ptr      = 0;
  int stalled  = 0;
  int cnt      = 0;
  bit aborted  = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] c, input logic [N-1:0] s,
                      input logic a, input logic e, input logic y);
    exp_t x;
    int   pulse;
    @(negedge clk_i);
    rst_i = r; cyc_i = c; stb_i = s; ack_i = a; err_i = e; rty_i = y;
    pulse = 0;
    if (r) begin
      owner = -1; last_idx = 0; ptr = 0; stalled = 0; cnt = 0; aborted = 1'b0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && c[(ptr + k) % N]) owner = (ptr + k) % N;
      end
      if (owner >= 0) last_idx = owner;
      stalled = 0;
      aborted = 1'b0;
    end else if (!c[owner]) begin
      ptr = (owner + 1) % N;
      owner = -1;
      stalled = 0;
      aborted = 1'b0;
    end else if (TO_EN && !aborted) begin
      if (s[owner] && !(a || e || y)) begin
        stalled++;
        if (stalled == T) begin
          pulse = 1;
          aborted = 1'b1;
          stalled = 0;
          if (cnt < 65535) cnt++;
        end
      end else begin
        stalled = 0;
      end
    end
    x.gnt  = (owner < 0) ? 0 : (1 << owner);
    x.idx  = last_idx;
    x.busy = (owner >= 0) ? 1 : 0;
    x.err  = pulse;
    x.cnt  = cnt;
    sb_q.push_back(x);
  endtask

  // Monitor: compare each post-edge DUT state against the queued expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("gnt_o", int'(gnt_o), x.gnt);
        chk("gnt_idx_o", int'(gnt_idx_o), x.idx);
        chk("busy_o", int'(busy_o), x.busy);
        chk("to_err_o", int'(to_err_o), x.err);
        chk("to_count_o", int'(to_count_o), x.cnt);
      end
    end
  end

  initial begin
    logic [N-1:0] c;
    logic [N-1:0] cr;
    int held;
    bit quiet;
    rst_i = 1'b1; cyc_i = '0; stb_i = '0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    step(1, 4'h0, 4'h0, 0, 0, 0);
    step(1, 4'h3, 4'h0, 0, 0, 0);

    // two requesters from reset, master 0 first, then master 1 after a dead cycle
    for (int i = 0; i < 4; i++) step(0, 4'h3, 4'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4'h2, 4'h0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 4'h0, 4'h0, 0, 0, 0);

    // all four requesting, each releases after three granted cycles
    step(1, 4'h0, 4'h0, 0, 0, 0);
    held = 0;
    for (int i = 0; i < 24; i++) begin
      c = 4'hF;
      if (owner >= 0 && held >= 3) c[owner] = 1'b0;
      step(0, c, 4'h0, 0, 0, 0);
      held = (owner >= 0) ? held + 1 : 0;
    end

    // unterminated strobe on master 0
    step(1, 4'h0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 4'h1, 4'h1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 4'h0, 4'h0, 0, 0, 0);

    // ack lands on the last stalled cycle before timeout
    step(0, 4'h2, 4'h2, 0, 0, 0);
    for (int i = 0; i < T; i++) step(0, 4'h2, 4'h2, (i == T - 1), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 4'h2, 4'h2, 0, 0, 0);
    step(0, 4'h0, 4'h0, 0, 0, 0);

    // reset in the middle of master 1's grant, master 0 then wins
    step(1, 4'h0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 4'h2, 4'h2, 0, 0, 0);
    step(1, 4'h3, 4'h3, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 4'h3, 4'h0, 0, 0, 0);
    step(0, 4'h0, 4'h0, 0, 0, 0);

    // long unterminated strobe on master 2
    step(1, 4'h0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) step(0, 4'h4, 4'h4, 0, 0, 0);
    step(0, 4'h0, 4'h0, 0, 0, 0);

    // randomized traffic
    cr = '0;
    quiet = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 100 == 0) quiet = ($urandom_range(0, 1) == 1);
      for (int m = 0; m < N; m++) if ($urandom_range(0, 5) == 0) cr[m] = ~cr[m];
      step(($urandom_range(0, 299) == 0), cr, N'($urandom),
           !quiet && ($urandom_range(0, 9) == 0),
           !quiet && ($urandom_range(0, 19) == 0),
           !quiet && ($urandom_range(0, 19) == 0));
    end

    @(negedge clk_i);
    @(negedge clk_i);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
